// File: rtl/pattern_matcher_pkg.sv
// Shared definitions for the multi-pattern byte-stream matcher.
// Mode and FSM encodings, saturation limits and the lane length clamp.
package pattern_matcher_pkg;

    localparam logic MODE_ANY = 1'b0;
    localparam logic MODE_SEQ = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [7:0]  BYTES_SAT = 8'hFF;
    localparam logic [15:0] CNT_SAT   = 16'hFFFF;

    function automatic logic [7:0] clamp_len(
        input logic [7:0] len,
        input logic [7:0] max_len
    );
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/pattern_lane_cmp.sv
// One masked pattern lane: compares the byte window against a pattern.
// Bytes at or beyond the lane length never take part in the compare.
module pattern_lane_cmp
    import pattern_matcher_pkg::*;
#(
    parameter int pPATTERN_BYTES = 8
) (
    input  logic [pPATTERN_BYTES*8-1:0] window,
    input  logic [pPATTERN_BYTES*8-1:0] pattern,
    input  logic [pPATTERN_BYTES*8-1:0] mask,
    input  logic [7:0]                  len,
    output logic                        match
);

    localparam logic [7:0] B8 = 8'(pPATTERN_BYTES);

    logic [7:0] eff;
    logic       ok;

    always_comb begin
        eff = clamp_len(len, B8);
        ok  = 1'b1;
        for (int i = 0; i < pPATTERN_BYTES; i++) begin
            if (8'(i) < eff) begin
                if (((window[i*8 +: 8] ^ pattern[i*8 +: 8])
                     & mask[i*8 +: 8]) != 8'h00) begin
                    ok = 1'b0;
                end
            end
        end
        match = (eff != 8'd0) && ok;
    end

endmodule

// File: rtl/pattern_matcher_multi.sv
// Multi-lane pattern matcher with ANY / SEQUENCE modes, holdoff and
// self-disarm after a programmed trigger count.
module pattern_matcher_multi
    import pattern_matcher_pkg::*;
#(
    parameter int pNUM_PATTERNS  = 4,
    parameter int pPATTERN_BYTES = 8,
    parameter int pID_WIDTH      = 3
) (
    input  logic                                      fe_clk,
    input  logic                                      reset_i,
    input  logic                                      I_arm,
    input  logic                                      I_mode,
    input  logic [pNUM_PATTERNS*pPATTERN_BYTES*8-1:0] I_pattern,
    input  logic [pNUM_PATTERNS*pPATTERN_BYTES*8-1:0] I_mask,
    input  logic [pNUM_PATTERNS*8-1:0]                I_pattern_bytes,
    input  logic [15:0]                               I_num_triggers,
    input  logic [15:0]                               I_holdoff,
    input  logic [15:0]                               I_seq_timeout,
    input  logic [7:0]                                I_fe_data,
    input  logic                                      I_fe_data_valid,
    output logic                                      O_match_trigger,
    output logic [pID_WIDTH-1:0]                      O_match_id,
    output logic [15:0]                               O_num_triggers,
    output logic                                      O_armed,
    output logic                                      O_disarm_pulse
);

    localparam int N  = pNUM_PATTERNS;
    localparam int B  = pPATTERN_BYTES;
    localparam int ML = 1 << pID_WIDTH;
    localparam logic [7:0] B8 = 8'(B);

    state_e                 state;
    logic                   arm_q;
    logic                   mode_q;
    logic [7:0]             d1;
    logic                   v1;
    logic [(B-1)*8-1:0]     hist;
    logic [B*8-1:0]         window;
    logic [7:0]             rcvd;
    logic [15:0]            hold_cnt;
    logic [15:0]            tcnt;
    logic [15:0]            tcnt_nxt;
    logic [15:0]            trig_cnt;
    logic [15:0]            cnt_inc;
    logic [pID_WIDTH-1:0]   stage;
    logic [pID_WIDTH-1:0]   stage_nxt;
    logic [pID_WIDTH-1:0]   last_en;
    logic [pID_WIDTH-1:0]   next_en;
    logic [pID_WIDTH-1:0]   low_id;
    logic [pID_WIDTH-1:0]   fire_id;
    logic [pID_WIDTH-1:0]   match_id;
    logic [N-1:0]           cmp;
    logic [N-1:0]           hit;
    logic [N-1:0]           en;
    logic [ML-1:0]          hit_pad;
    logic                   fire;
    logic                   trig_q;
    logic                   dis_q;

    // The current byte is compared before it enters the history.
    assign window = {hist, d1};

    for (genvar p = 0; p < N; p++) begin : g_lane
        pattern_lane_cmp #(
            .pPATTERN_BYTES(B)
        ) u_lane (
            .window (window),
            .pattern(I_pattern[p*B*8 +: B*8]),
            .mask   (I_mask[p*B*8 +: B*8]),
            .len    (I_pattern_bytes[p*8 +: 8]),
            .match  (cmp[p])
        );
    end

    always_comb begin
        en  = '0;
        hit = '0;
        for (int p = 0; p < N; p++) begin
            en[p]  = |I_pattern_bytes[p*8 +: 8];
            hit[p] = cmp[p]
                   && ({1'b0, rcvd} + 9'd1
                       >= {1'b0, clamp_len(I_pattern_bytes[p*8 +: 8], B8)});
        end
        hit_pad        = '0;
        hit_pad[N-1:0] = hit;
    end

    always_comb begin
        low_id  = '0;
        last_en = '0;
        next_en = '0;
        for (int p = N - 1; p >= 0; p--) begin
            if (hit[p]) low_id = pID_WIDTH'(p);
            if (en[p] && pID_WIDTH'(p) > stage) next_en = pID_WIDTH'(p);
        end
        for (int p = 0; p < N; p++) begin
            if (en[p]) last_en = pID_WIDTH'(p);
        end
    end

    always_comb begin
        fire      = 1'b0;
        fire_id   = '0;
        stage_nxt = stage;
        tcnt_nxt  = tcnt;
        if (mode_q == MODE_ANY) begin
            if (|hit) begin
                fire    = 1'b1;
                fire_id = low_id;
            end
        end else if (hit_pad[stage]) begin
            tcnt_nxt = '0;
            if (stage == last_en) begin
                fire      = 1'b1;
                fire_id   = stage;
                stage_nxt = '0;
            end else begin
                stage_nxt = next_en;
            end
        end else begin
            tcnt_nxt = (tcnt == CNT_SAT) ? tcnt : tcnt + 16'd1;
            if (I_seq_timeout != 16'd0 && tcnt_nxt >= I_seq_timeout) begin
                stage_nxt = '0;
                tcnt_nxt  = '0;
            end
        end
    end

    assign cnt_inc = (trig_cnt == CNT_SAT) ? trig_cnt : trig_cnt + 16'd1;

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state    <= ST_IDLE;
            arm_q    <= 1'b0;
            mode_q   <= MODE_ANY;
            d1       <= '0;
            v1       <= 1'b0;
            hist     <= '0;
            rcvd     <= '0;
            hold_cnt <= '0;
            tcnt     <= '0;
            trig_cnt <= '0;
            stage    <= '0;
            match_id <= '0;
            trig_q   <= 1'b0;
            dis_q    <= 1'b0;
        end else begin
            arm_q  <= I_arm;
            d1     <= I_fe_data;
            v1     <= I_fe_data_valid;
            trig_q <= 1'b0;
            dis_q  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (I_arm && !arm_q) begin
                        state    <= ST_ARMED;
                        mode_q   <= I_mode;
                        hist     <= '0;
                        rcvd     <= '0;
                        hold_cnt <= '0;
                        tcnt     <= '0;
                        stage    <= '0;
                        trig_cnt <= '0;
                    end
                end
                ST_ARMED: begin
                    if (!I_arm) begin
                        state <= ST_IDLE;
                    end else if (v1) begin
                        hist <= window[(B-1)*8-1:0];
                        if (rcvd != BYTES_SAT) rcvd <= rcvd + 8'd1;
                        if (hold_cnt != 16'd0) begin
                            hold_cnt <= hold_cnt - 16'd1;
                        end else begin
                            stage <= stage_nxt;
                            tcnt  <= tcnt_nxt;
                            if (fire) begin
                                trig_q   <= 1'b1;
                                match_id <= fire_id;
                                trig_cnt <= cnt_inc;
                                hold_cnt <= I_holdoff;
                                if (I_num_triggers != 16'd0
                                    && cnt_inc == I_num_triggers) begin
                                    state <= ST_DONE;
                                    dis_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (!I_arm) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign O_match_trigger = trig_q;
    assign O_match_id      = match_id;
    assign O_num_triggers  = trig_cnt;
    assign O_armed         = (state == ST_ARMED);
    assign O_disarm_pulse  = dis_q;

endmodule

// File: tb/tb_pattern_matcher_multi.sv
// Directed bench for pattern_matcher_multi with a queue-based
// reference model compared every cycle plus literal expectations.
module tb_pattern_matcher_multi;

    localparam int N   = 4;
    localparam int B   = 8;
    localparam int IDW = 3;

    logic               fe_clk = 1'b0;
    logic               reset_i;
    logic               I_arm;
    logic               I_mode;
    logic [N*B*8-1:0]   I_pattern;
    logic [N*B*8-1:0]   I_mask;
    logic [N*8-1:0]     I_pattern_bytes;
    logic [15:0]        I_num_triggers;
    logic [15:0]        I_holdoff;
    logic [15:0]        I_seq_timeout;
    logic [7:0]         I_fe_data;
    logic               I_fe_data_valid;
    logic               O_match_trigger;
    logic [IDW-1:0]     O_match_id;
    logic [15:0]        O_num_triggers;
    logic               O_armed;
    logic               O_disarm_pulse;

    pattern_matcher_multi #(
        .pNUM_PATTERNS (N),
        .pPATTERN_BYTES(B),
        .pID_WIDTH     (IDW)
    ) dut (
        .fe_clk         (fe_clk),
        .reset_i        (reset_i),
        .I_arm          (I_arm),
        .I_mode         (I_mode),
        .I_pattern      (I_pattern),
        .I_mask         (I_mask),
        .I_pattern_bytes(I_pattern_bytes),
        .I_num_triggers (I_num_triggers),
        .I_holdoff      (I_holdoff),
        .I_seq_timeout  (I_seq_timeout),
        .I_fe_data      (I_fe_data),
        .I_fe_data_valid(I_fe_data_valid),
        .O_match_trigger(O_match_trigger),
        .O_match_id     (O_match_id),
        .O_num_triggers (O_num_triggers),
        .O_armed        (O_armed),
        .O_disarm_pulse (O_disarm_pulse)
    );

    always #5 fe_clk = ~fe_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit run = 1'b0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: byte history as a queue, rules applied per byte.
    bit         m_armed = 0, m_done = 0, m_arm_prev = 0;
    bit         m_v1 = 0, m_seq = 0;
    logic [7:0] m_d1 = 0;
    logic [7:0] m_hist[$];
    int         m_rcvd = 0, m_hold = 0, m_stage = 0;
    int         m_gap = 0, m_cnt = 0;
    bit         e_trig = 0, e_dis = 0;
    int         e_id = 0;

    function automatic int lane_len(input int p);
        int l;
        l = int'(I_pattern_bytes[p*8 +: 8]);
        return (l > B) ? B : l;
    endfunction

    function automatic bit lane_hit(input int p, input logic [7:0] cur);
        int l;
        logic [7:0] b, pt, mk;
        l = lane_len(p);
        if (l == 0 || m_rcvd < l - 1) return 0;
        for (int i = 0; i < l; i++) begin
            if (i == 0) b = cur;
            else if (i - 1 < m_hist.size()) b = m_hist[i-1];
            else b = 8'h00;
            pt = I_pattern[(p*B + i)*8 +: 8];
            mk = I_mask[(p*B + i)*8 +: 8];
            if ((b & mk) != (pt & mk)) return 0;
        end
        return 1;
    endfunction

    task automatic m_fire(input int p);
        e_trig = 1;
        e_id = p;
        if (m_cnt < 65535) m_cnt++;
        m_hold = int'(I_holdoff);
        if (I_num_triggers != 0 && m_cnt == int'(I_num_triggers)) begin
            m_armed = 0;
            m_done = 1;
            e_dis = 1;
        end
    endtask

    task automatic m_byte(input logic [7:0] cur);
        bit h[N];
        int last, nxt;
        for (int p = 0; p < N; p++) h[p] = lane_hit(p, cur);
        m_hist.push_front(cur);
        if (m_hist.size() > 16) void'(m_hist.pop_back());
        if (m_rcvd < 255) m_rcvd++;
        if (m_hold > 0) begin
            m_hold--;
        end else if (!m_seq) begin
            for (int p = N - 1; p >= 0; p--) if (h[p]) nxt = p;
            for (int p = 0; p < N; p++) if (h[p]) begin
                m_fire(nxt);
                break;
            end
        end else if (h[m_stage]) begin
            m_gap = 0;
            last = 0;
            for (int p = 0; p < N; p++) if (lane_len(p) > 0) last = p;
            if (m_stage == last) begin
                m_fire(m_stage);
                m_stage = 0;
            end else begin
                nxt = 0;
                for (int p = N - 1; p > m_stage; p--)
                    if (lane_len(p) > 0) nxt = p;
                m_stage = nxt;
            end
        end else begin
            m_gap++;
            if (I_seq_timeout != 0 && m_gap >= int'(I_seq_timeout)) begin
                m_stage = 0;
                m_gap = 0;
            end
        end
    endtask

    always @(posedge fe_clk) begin
        cyc++;
        e_trig = 0;
        e_dis = 0;
        if (reset_i) begin
            m_armed = 0; m_done = 0; m_arm_prev = 0;
            m_v1 = 0; m_d1 = 0; m_seq = 0;
            m_hist.delete();
            m_rcvd = 0; m_hold = 0; m_stage = 0;
            m_gap = 0; m_cnt = 0; e_id = 0;
        end else begin
            if (!m_armed && !m_done) begin
                if (I_arm && !m_arm_prev) begin
                    m_armed = 1;
                    m_seq = I_mode;
                    m_hist.delete();
                    m_rcvd = 0; m_hold = 0; m_stage = 0;
                    m_gap = 0; m_cnt = 0;
                end
            end else if (!I_arm) begin
                m_armed = 0;
                m_done = 0;
            end else if (m_armed && m_v1) begin
                m_byte(m_d1);
            end
            m_arm_prev = I_arm;
            m_v1 = I_fe_data_valid;
            m_d1 = I_fe_data;
        end
    end

    int n_trig = 0, n_dis = 0, last_trig_cyc = 0;

    always @(negedge fe_clk) begin
        if (run) begin
            chk("trig", int'(O_match_trigger), int'(e_trig));
            chk("id", int'(O_match_id), e_id);
            chk("count", int'(O_num_triggers), m_cnt);
            chk("armed", int'(O_armed), int'(m_armed));
            chk("disarm", int'(O_disarm_pulse), int'(e_dis));
            if (O_match_trigger) begin
                n_trig++;
                last_trig_cyc = cyc;
            end
            if (O_disarm_pulse) n_dis++;
        end
    end

    int byte_cyc = 0;

    task automatic send(input logic [7:0] b);
        @(posedge fe_clk); #1;
        I_fe_data = b;
        I_fe_data_valid = 1'b1;
        byte_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge fe_clk); #1;
            I_fe_data_valid = 1'b0;
        end
    endtask

    task automatic clr_cfg();
        I_pattern = '0;
        I_mask = '0;
        I_pattern_bytes = '0;
        I_num_triggers = 16'd0;
        I_holdoff = 16'd0;
        I_seq_timeout = 16'd0;
    endtask

    task automatic set_lane(input int p, input int len,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] mk);
        for (int i = 0; i < B; i++) begin
            I_pattern[(p*B + i)*8 +: 8] = 8'h00;
            I_mask[(p*B + i)*8 +: 8] = mk;
        end
        I_pattern[(p*B)*8 +: 8] = b0;
        I_pattern[(p*B + 1)*8 +: 8] = b1;
        I_pattern_bytes[p*8 +: 8] = 8'(len);
    endtask

    task automatic arm(input logic m);
        @(posedge fe_clk); #1;
        I_arm = 1'b0;
        I_fe_data_valid = 1'b0;
        @(posedge fe_clk); #1;
        I_arm = 1'b1;
        I_mode = m;
        @(posedge fe_clk); #1;
    endtask

    int n0, d0, c0;

    initial begin
        reset_i = 1'b1;
        I_arm = 1'b0;
        I_mode = 1'b0;
        I_fe_data = 8'h00;
        I_fe_data_valid = 1'b0;
        clr_cfg();
        @(posedge fe_clk); #1;
        run = 1'b1;
        repeat (2) @(posedge fe_clk);
        #1 reset_i = 1'b0;
        chk("rst_count", int'(O_num_triggers), 0);
        chk("rst_armed", int'(O_armed), 0);
        chk("rst_id", int'(O_match_id), 0);

        // ANY, two-byte pattern, single trigger then self-disarm
        clr_cfg();
        set_lane(0, 2, 8'h00, 8'h2D, 8'hFF);
        I_num_triggers = 16'd1;
        n0 = n_trig; d0 = n_dis;
        arm(1'b0);
        send(8'h2D);
        send(8'h00);
        c0 = byte_cyc;
        idle(4);
        chk("t1_pulses", n_trig - n0, 1);
        chk("t1_latency", last_trig_cyc - c0, 2);
        chk("t1_disarm", n_dis - d0, 1);
        chk("t1_count", int'(O_num_triggers), 1);
        chk("t1_id", int'(O_match_id), 0);
        chk("t1_armed", int'(O_armed), 0);
        send(8'h2D);
        send(8'h00);
        idle(4);
        chk("t1_done_quiet", n_trig - n0, 1);

        // bytes_received gating of a two-byte zero pattern
        clr_cfg();
        set_lane(0, 2, 8'h00, 8'h00, 8'hFF);
        n0 = n_trig;
        arm(1'b0);
        send(8'h00);
        idle(3);
        chk("t1b_first", n_trig - n0, 0);
        send(8'h00);
        idle(3);
        chk("t1b_second", n_trig - n0, 1);

        // ANY priority and masking
        clr_cfg();
        set_lane(1, 1, 8'hA5, 8'h00, 8'hFF);
        set_lane(2, 1, 8'hA5, 8'h00, 8'hFF);
        n0 = n_trig;
        arm(1'b0);
        send(8'hA5);
        idle(3);
        chk("t2_pulses", n_trig - n0, 1);
        chk("t2_id", int'(O_match_id), 1);
        send(8'hA7);
        idle(3);
        chk("t2_nomask", n_trig - n0, 1);
        set_lane(1, 1, 8'hA5, 8'h00, 8'hF0);
        send(8'hA7);
        idle(3);
        chk("t2_mask", n_trig - n0, 2);
        chk("t2_mask_id", int'(O_match_id), 1);

        // SEQUENCE with timeout 3
        clr_cfg();
        set_lane(0, 1, 8'h11, 8'h00, 8'hFF);
        set_lane(1, 1, 8'h22, 8'h00, 8'hFF);
        I_seq_timeout = 16'd3;
        n0 = n_trig;
        arm(1'b1);
        send(8'h11); send(8'h33); send(8'h33); send(8'h22);
        idle(3);
        chk("t3_inwin", n_trig - n0, 1);
        chk("t3_id", int'(O_match_id), 1);
        send(8'h11); send(8'h33); send(8'h33); send(8'h33);
        send(8'h22);
        idle(3);
        chk("t3_timeout", n_trig - n0, 1);

        // holdoff of 2 bytes
        clr_cfg();
        set_lane(0, 1, 8'h55, 8'h00, 8'hFF);
        I_holdoff = 16'd2;
        n0 = n_trig;
        arm(1'b0);
        send(8'h55);
        c0 = byte_cyc;
        send(8'h55); send(8'h55); send(8'h55);
        idle(3);
        chk("t4_pulses", n_trig - n0, 2);
        chk("t4_last", last_trig_cyc - c0, 5);

        // unlimited triggers, then arm dropped mid-stream
        I_holdoff = 16'd0;
        n0 = n_trig; d0 = n_dis;
        arm(1'b0);
        for (int i = 0; i < 300; i++) send(8'h55);
        idle(3);
        chk("t5_count", int'(O_num_triggers), 300);
        chk("t5_nodisarm", n_dis - d0, 0);
        chk("t5_armed", int'(O_armed), 1);
        send(8'h55);
        send(8'h55);
        @(posedge fe_clk); #1;
        I_arm = 1'b0;
        repeat (3) @(posedge fe_clk);
        #1 I_fe_data_valid = 1'b0;
        idle(4);
        chk("t5_drop_count", int'(O_num_triggers), 301);
        chk("t5_drop_armed", int'(O_armed), 0);
        chk("t5_drop_pulses", n_trig - n0, 301);

        // reset while a match is in flight
        clr_cfg();
        set_lane(2, 1, 8'h55, 8'h00, 8'hFF);
        arm(1'b0);
        send(8'h55);
        idle(3);
        chk("t6_pre_id", int'(O_match_id), 2);
        chk("t6_pre_count", int'(O_num_triggers), 1);
        n0 = n_trig;
        send(8'h55);
        @(posedge fe_clk); #1;
        reset_i = 1'b1;
        I_fe_data_valid = 1'b0;
        @(posedge fe_clk); #1;
        chk("t6_trig", int'(O_match_trigger), 0);
        chk("t6_id", int'(O_match_id), 0);
        chk("t6_count", int'(O_num_triggers), 0);
        chk("t6_armed", int'(O_armed), 0);
        chk("t6_disarm", int'(O_disarm_pulse), 0);
        reset_i = 1'b0;
        I_arm = 1'b0;
        idle(3);
        chk("t6_pulses", n_trig - n0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
